// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low 7-segment bus: qualifies each
// digit strobe for stability, decodes the glyph and flags malformed bus states.
module seg7_scan_decoder #(
  parameter int unsigned N_DIGITS      = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   anodes_in,
  input  logic [6:0]            segments_in,
  output logic [4*N_DIGITS-1:0] value_out,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  invalid_pattern,
  output logic                  onehot_error,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned POP_W = $clog2(N_DIGITS + 1);
  localparam logic [6:0]  BLANK = 7'h7F;

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [6:0]          r_seg;
  logic [4*N_DIGITS-1:0] r_value;
  logic [N_DIGITS-1:0] r_valid;
  logic [N_DIGITS-1:0] r_seen;
  logic                r_invalid;
  logic                r_onehot_err;
  logic                r_frame;

  logic [POP_W-1:0]    w_lows;
  logic [IDX_W-1:0]    w_idx;
  logic                w_cand;
  logic                w_multi;
  logic                w_same;
  logic                w_accept;
  logic                w_glyph;
  logic                w_blank;
  logic [3:0]          w_nib;
  logic [N_DIGITS-1:0] w_seen_nxt;
  logic                w_frame;

  // Count low anodes and remember the index of the (last) low one.
  always_comb begin
    w_lows = '0;
    w_idx  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!anodes_in[i]) begin
        w_lows = w_lows + POP_W'(1);
        w_idx  = IDX_W'(i);
      end
    end
  end

  assign w_cand  = (w_lows == POP_W'(1));
  assign w_multi = (w_lows > POP_W'(1));
  assign w_same  = (w_idx == r_idx) && (segments_in == r_seg);

  // Glyph lookup on the raw active-low segment pattern.
  always_comb begin
    w_glyph = 1'b1;
    w_nib   = 4'h0;
    case (segments_in)
      7'h01: w_nib = 4'h0;
      7'h4F: w_nib = 4'h1;
      7'h12: w_nib = 4'h2;
      7'h06: w_nib = 4'h3;
      7'h4C: w_nib = 4'h4;
      7'h24: w_nib = 4'h5;
      7'h20: w_nib = 4'h6;
      7'h0F: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h04: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h60: w_nib = 4'hB;
      7'h31: w_nib = 4'hC;
      7'h42: w_nib = 4'hD;
      7'h30: w_nib = 4'hE;
      7'h38: w_nib = 4'hF;
      default: w_glyph = 1'b0;
    endcase
  end

  assign w_blank = (segments_in == BLANK);

  // Stability tracker next-state; acceptance fires on the edge the count hits the target.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cand) begin
          w_state_nxt = S_TRACK;
          w_count_nxt = CNT_W'(1);
        end
      end
      S_TRACK: begin
        if (!w_cand) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (w_same) begin
          w_count_nxt = (r_count == CNT_W'(STABLE_CYCLES)) ? r_count : r_count + CNT_W'(1);
        end else begin
          w_count_nxt = CNT_W'(1);
        end
      end
      S_LOCKED: begin
        if (!w_cand) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (!w_same) begin
          w_state_nxt = S_TRACK;
          w_count_nxt = CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
    if ((w_state_nxt == S_TRACK) && (w_count_nxt == CNT_W'(STABLE_CYCLES))) begin
      w_state_nxt = S_LOCKED;
      w_accept    = 1'b1;
    end
  end

  always_comb begin
    w_seen_nxt = r_seen;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_idx == IDX_W'(i)) w_seen_nxt[i] = 1'b1;
    end
  end

  assign w_frame = w_accept && (w_seen_nxt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_seg   <= BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_cand) begin
        r_idx <= w_idx;
        r_seg <= segments_in;
      end
    end
  end

  // Decoded outputs, pulses and frame bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value      <= '0;
      r_valid      <= '0;
      r_seen       <= '0;
      r_invalid    <= 1'b0;
      r_onehot_err <= 1'b0;
      r_frame      <= 1'b0;
    end else begin
      r_onehot_err <= w_multi;
      r_invalid    <= w_accept && !w_glyph && !w_blank;
      r_frame      <= w_frame;
      if (w_accept) begin
        r_seen <= w_frame ? '0 : w_seen_nxt;
        for (int i = 0; i < N_DIGITS; i++) begin
          if (w_idx == IDX_W'(i)) begin
            r_valid[i] <= w_glyph;
            if (w_glyph) r_value[4*i +: 4] <= w_nib;
          end
        end
      end
    end
  end

  assign value_out       = r_value;
  assign digit_valid     = r_valid;
  assign invalid_pattern = r_invalid;
  assign onehot_error    = r_onehot_err;
  assign frame_done      = r_frame;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus random bus
// traffic compared against a sample-history reference model.
module tb_seg7_scan_decoder;

  localparam int unsigned N = 8;
  localparam int unsigned S = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  anodes_in;
  logic [6:0]    segments_in;
  logic [4*N-1:0] value_out;
  logic [N-1:0]  digit_valid;
  logic          invalid_pattern;
  logic          onehot_error;
  logic          frame_done;

  seg7_scan_decoder #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .anodes_in(anodes_in), .segments_in(segments_in),
    .value_out(value_out), .digit_valid(digit_valid), .invalid_pattern(invalid_pattern),
    .onehot_error(onehot_error), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int inv_cnt = 0;

  // Reference model: expected outputs plus the recent sample history.
  logic [4*N-1:0] m_value;
  logic [N-1:0]   m_valid, m_seen;
  logic           m_inv, m_oh, m_fd;
  int             hist[$];

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_value = '0; m_valid = '0; m_seen = '0;
    m_inv = 1'b0; m_oh = 1'b0; m_fd = 1'b0;
    hist.delete();
  endtask

  // A digit is accepted when the newest S samples are one identical candidate
  // and the sample before them (if any since reset) was something else.
  task automatic model_sample(logic [N-1:0] an, logic [6:0] seg);
    int  lows = 0;
    int  idx = 0;
    int  code;
    int  hit = -1;
    bit  acc;
    for (int i = 0; i < N; i++) if (!an[i]) begin lows++; idx = i; end
    code = (lows == 1) ? idx * 128 + int'(seg) : -1;
    m_oh = (lows > 1); m_inv = 1'b0; m_fd = 1'b0;
    hist.push_back(code);
    if (hist.size() > S + 1) void'(hist.pop_front());
    acc = (code >= 0) && (hist.size() >= S);
    if (acc) begin
      for (int k = 0; k < S; k++) if (hist[hist.size() - 1 - k] != code) acc = 0;
      if (hist.size() == S + 1 && hist[0] == code) acc = 0;
    end
    if (acc) begin
      for (int g = 0; g < 16; g++) if (GLYPH[g] == seg) hit = g;
      if (hit >= 0) begin
        m_value[idx*4 +: 4] = 4'(hit);
        m_valid[idx] = 1'b1;
      end else begin
        m_valid[idx] = 1'b0;
        if (seg != 7'h7F) m_inv = 1'b1;
      end
      m_seen[idx] = 1'b1;
      if (m_seen == '1) begin m_fd = 1'b1; m_seen = '0; end
    end
  endtask

  task automatic compare_all(string tag);
    check_eq({tag, ".value"}, 64'(value_out), 64'(m_value));
    check_eq({tag, ".valid"}, 64'(digit_valid), 64'(m_valid));
    check_eq({tag, ".inv"}, 64'(invalid_pattern), 64'(m_inv));
    check_eq({tag, ".oh"}, 64'(onehot_error), 64'(m_oh));
    check_eq({tag, ".fd"}, 64'(frame_done), 64'(m_fd));
  endtask

  task automatic step(string tag, logic [N-1:0] an, logic [6:0] seg);
    anodes_in = an;
    segments_in = seg;
    @(posedge clk);
    model_sample(an, seg);
    #1;
    if (frame_done === 1'b1) fd_cnt++;
    if (invalid_pattern === 1'b1) inv_cnt++;
    compare_all(tag);
  endtask

  task automatic hold(string tag, logic [N-1:0] an, logic [6:0] seg, int n);
    repeat (n) step(tag, an, seg);
  endtask

  function automatic logic [N-1:0] sel(int d);
    return ~(N'(1) << d);
  endfunction

  // Asynchronous reset mid-operation: outputs must clear before any clock edge.
  task automatic async_reset(string tag);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_eq({tag, ".value"}, 64'(value_out), 64'd0);
    check_eq({tag, ".valid"}, 64'(digit_valid), 64'd0);
    check_eq({tag, ".pulses"}, 64'({invalid_pattern, onehot_error, frame_done}), 64'd0);
    anodes_in = '1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    anodes_in = '1;
    segments_in = 7'h7F;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // Single digit acceptance latency, then no re-accept while held.
    hold("t1.pre", sel(0), 7'h12, 3);
    check_eq("t1.not_before", 64'(digit_valid), 64'd0);
    step("t1.acc", sel(0), 7'h12);
    check_eq("t1.nib", 64'(value_out[3:0]), 64'd2);
    check_eq("t1.valid", 64'(digit_valid), 64'h01);
    inv_cnt = 0; fd_cnt = 0;
    hold("t1.hold", sel(0), 7'h12, 10);
    check_eq("t1.no_pulse", 64'(inv_cnt + fd_cnt), 64'd0);

    // Full scan of glyphs 0..7.
    fd_cnt = 0;
    for (int d = 0; d < 8; d++) hold("t2.scan", sel(d), GLYPH[d], 4);
    check_eq("t2.value", 64'(value_out), 64'h76543210);
    check_eq("t2.valid", 64'(digit_valid), 64'hFF);
    check_eq("t2.frames", 64'(fd_cnt), 64'd1);

    // Invalid pattern then blank on digit 3.
    inv_cnt = 0;
    hold("t3.inv", sel(3), 7'h55, 4);
    check_eq("t3.inv_cnt", 64'(inv_cnt), 64'd1);
    check_eq("t3.valid3", 64'(digit_valid[3]), 64'd0);
    check_eq("t3.value", 64'(value_out), 64'h76543210);
    hold("t3.blank", sel(3), 7'h7F, 4);
    check_eq("t3.blank_inv", 64'(inv_cnt), 64'd1);
    check_eq("t3.blank_valid3", 64'(digit_valid[3]), 64'd0);

    // Toggling faster than the stability window never accepts.
    async_reset("t4.rst");
    for (int t = 0; t < 6; t++) hold("t4.toggle", sel(0), (t % 2 == 0) ? 7'h01 : 7'h4F, 3);
    check_eq("t4.valid", 64'(digit_valid), 64'd0);

    // Multi-anode sample flags an error and leaves outputs alone.
    hold("t5.multi", 8'hFC, 7'h01, 2);
    check_eq("t5.oh", 64'(onehot_error), 64'd1);
    hold("t5.f", sel(0), 7'h38, 4);
    check_eq("t5.nibF", 64'(value_out[3:0]), 64'hF);

    // Reset mid-TRACK after a partial frame; a whole new frame is then required.
    for (int d = 0; d < 3; d++) hold("t6.part", sel(d), GLYPH[d + 8], 4);
    hold("t6.track", sel(3), 7'h06, 2);
    async_reset("t6.rst");
    fd_cnt = 0;
    for (int d = 1; d < 8; d++) hold("t6.scan", sel(d), GLYPH[d], 4);
    check_eq("t6.no_frame", 64'(fd_cnt), 64'd0);
    hold("t6.last", sel(0), GLYPH[0], 4);
    check_eq("t6.frame", 64'(fd_cnt), 64'd1);

    // Random bus traffic.
    for (int r = 0; r < 400; r++) begin
      int unsigned ac = $urandom_range(0, 9);
      int unsigned sc = $urandom_range(0, 9);
      logic [N-1:0] an;
      logic [6:0]   seg;
      if (ac < 8)       an = sel(int'($urandom_range(0, N - 1)));
      else if (ac == 8) an = '1;
      else              an = N'($urandom);
      if (sc < 7)       seg = GLYPH[$urandom_range(0, 15)];
      else if (sc == 7) seg = 7'h7F;
      else              seg = 7'($urandom);
      hold("rand", an, seg, int'($urandom_range(1, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
